mips16_sc_cpu: RTL and testbench
================================

MIPS16_SC_CPU -- requirements
Module: mips16_sc_cpu

Interface
REQ-001 SHALL have no parameters; imem 256x32, data memory 256x16, register file 32x16 are fixed.
REQ-002 clock  in  1  single clock, all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 instruction  out  32  instruction word at current PC.
REQ-005 op_code_out  out  6  instruction[31:26].
REQ-006 func_out  out  6  instruction[5:0].
REQ-007 alu_op_out  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mult, else zero result.
REQ-008 out  out  16  write-back data (ALU result, load data or hi/lo).
REQ-009 reg_data_out_a  out  16  register file read of rs.
REQ-010 reg_data_out_b  out  16  register file read of rt.
REQ-011 mem_to_reg_out  out  1  write-back from data memory (lw).
REQ-012 mem_write_en_out  out  1  data memory write (sw).
REQ-013 reg_write_en_out  out  1  register file write enable.
REQ-014 alu_reset_out  out  1  multiplier start/clear pulse.
REQ-015 imm_sl_out  out  1  ALU operand B = immediate.
REQ-016 br_sl_out  out  1  branch instruction (beq/bne).
REQ-017 breq_sl_out  out  1  1 = beq, 0 = bne.
REQ-018 reg_dest_out  out  1  destination rd (1) or rt (0).
REQ-019 jump_sl_out  out  1  j instruction.
REQ-020 jump_reg_sl_out  out  1  jr instruction.
REQ-021 instr_stall_sl_out  out  1  PC hold while multiply busy.
REQ-022 ready_out  out  1  multiplier idle/result valid.
REQ-023 hi_lo_sl_out  out  1  write-back selects hi (1) or lo (0) for mfhi/mflo.

Function
REQ-024 Single-cycle: fetch, decode, execute, write-back of one instruction per clock; outputs are combinational from current instruction and state.
REQ-025 Format: op[31:26] rs[25:21] rt[20:16] rd[15:11] func[5:0]; imm[15:0] used as full 16-bit operand; target[15:0] for j.
REQ-026 R-type (op 0x00) func: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), jr 0x08, mult 0x18, mfhi 0x10, mflo 0x12; writes rd except jr and mult.
REQ-027 I-type: addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D write rt; lw 0x23 rt<=dmem[rs+imm]; sw 0x2B dmem[rs+imm]<=rt; beq 0x04, bne 0x05; j 0x02.
REQ-028 Arithmetic modulo 2^16; data memory address = ALU result[7:0]; imem address = PC[7:0].
REQ-029 PC is 16-bit word index; next PC = PC+1, branch taken PC+1+imm, j target[15:0], jr rs; PC wraps at 0xFFFF.
REQ-030 Register 0 reads 0; writes to it ignored; reads of a register written the same cycle return old value.
REQ-031 Undefined op/func = nop: all enables 0, PC+1.
REQ-032 mult: first cycle alu_reset_out=1, operands latched, ready_out=0; 16-cycle shift-add unsigned; instr_stall_sl_out=1 and PC held until done; at completion edge {hi,lo}<=32-bit product, PC advances; total 17 cycles.
REQ-033 Hierarchy: instance d1 contains instruction_registers.register[0:255] (32-bit) and data_registers.register[0:31] (16-bit) so benches can preload and probe by path.

Reset
REQ-034 reset_n low asynchronously: PC=0, hi=lo=0, multiplier idle (ready_out=1, instr_stall_sl_out=0), register file all 0; imem and data memory not cleared.
REQ-035 Reset during multiply aborts it; hi/lo remain 0; execution restarts at PC 0 after release.

Verification
REQ-036 imem[0]=addi $1,$0,0x002A -> after 1 clock reg[1]=42, out=42, imm_sl_out=1, reg_write_en_out=1.
REQ-037 $1=5,$2=7; add $3,$1,$2; sub $4,$1,$2 -> reg[3]=12, reg[4]=0xFFFE; slt $5,$4,$1 -> 1.
REQ-038 sw $1,3($0) then lw $6,3($0) -> dmem[3]=42, reg[6]=42, mem_to_reg_out=1 on lw.
REQ-039 beq $1,$1,+2 at PC 4 -> next PC 7; bne same -> PC 5; j 0x0010 -> PC 16; jr $1 -> PC=reg[1].
REQ-040 $1=300,$2=300; mult; mflo $7; mfhi $8 -> stall 16 cycles, reg[7]=0x5F90, reg[8]=0x0001.
REQ-041 reset_n pulsed low mid-mult -> PC=0, ready_out=1 immediately, no hi/lo update.

Source files
------------

// File: rtl/mips16_sc_cpu.sv
// Single-cycle 16-bit MIPS-style CPU with 256x32 instruction memory, 32x16
// register file, 256x16 data memory and a 16-step shift-add multiplier (hi/lo).

module mips16_imem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [31:0] rdata_o
);
  logic [31:0] register [0:255];

  always_ff @(posedge clk_i) begin
    if (we_i) register[waddr_i] <= wdata_i;
  end

  assign rdata_o = register[raddr_i];
endmodule

module mips16_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [15:0] rdata_a_o,
  output logic [15:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [15:0] wdata_i
);
  logic [15:0] register [0:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) register[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      register[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 16'd0 : register[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 16'd0 : register[raddr_b_i];
endmodule

module mips16_dmem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);
  logic [15:0] mem [0:255];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];
endmodule

module mips16_datapath (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] instr_o,
  output logic [2:0]  alu_op_o,
  output logic [15:0] wb_data_o,
  output logic [15:0] rs_data_o,
  output logic [15:0] rt_data_o,
  output logic        mem_to_reg_o,
  output logic        mem_write_en_o,
  output logic        reg_write_en_o,
  output logic        alu_reset_o,
  output logic        imm_sl_o,
  output logic        br_sl_o,
  output logic        breq_sl_o,
  output logic        reg_dest_o,
  output logic        jump_sl_o,
  output logic        jump_reg_sl_o,
  output logic        stall_o,
  output logic        ready_o,
  output logic        hi_lo_sl_o
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_SLT = 3'b100, ALU_MULT = 3'b101, ALU_NONE = 3'b111;

  logic [15:0] pc_q, pc_d, hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [15:0] mplier_q, mplier_d;

  logic [31:0] instr;
  logic [5:0]  op, func;
  logic [15:0] imm, rs_data, rt_data, alu_b, alu_res, dmem_rdata, wb_data;
  logic [4:0]  wr_addr;
  logic [2:0]  alu_op;
  logic        imm_sl, reg_we, mem_we, mem_to_reg, br, breq, reg_dest, jump, jump_reg;
  logic        hilo_wb, hi_lo_sl, is_mult, alu_reset, mult_done, stall, br_taken;
  logic signed [15:0] alu_a_s, alu_b_s;

  mips16_imem instruction_registers (
    .clk_i(clk_i), .we_i(1'b0), .waddr_i(8'd0), .wdata_i(32'd0),
    .raddr_i(pc_q[7:0]), .rdata_o(instr)
  );

  assign op   = instr[31:26];
  assign func = instr[5:0];
  assign imm  = instr[15:0];

  always_comb begin
    alu_op = ALU_NONE; imm_sl = 1'b0; reg_we = 1'b0; mem_we = 1'b0; mem_to_reg = 1'b0;
    br = 1'b0; breq = 1'b0; reg_dest = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    hilo_wb = 1'b0; hi_lo_sl = 1'b0; is_mult = 1'b0;
    case (op)
      OP_R: begin
        case (func)
          F_ADD:  begin alu_op = ALU_ADD; reg_dest = 1'b1; reg_we = 1'b1; end
          F_SUB:  begin alu_op = ALU_SUB; reg_dest = 1'b1; reg_we = 1'b1; end
          F_AND:  begin alu_op = ALU_AND; reg_dest = 1'b1; reg_we = 1'b1; end
          F_OR:   begin alu_op = ALU_OR;  reg_dest = 1'b1; reg_we = 1'b1; end
          F_SLT:  begin alu_op = ALU_SLT; reg_dest = 1'b1; reg_we = 1'b1; end
          F_JR:   jump_reg = 1'b1;
          F_MULT: begin alu_op = ALU_MULT; is_mult = 1'b1; end
          F_MFHI: begin reg_dest = 1'b1; reg_we = 1'b1; hilo_wb = 1'b1; hi_lo_sl = 1'b1; end
          F_MFLO: begin reg_dest = 1'b1; reg_we = 1'b1; hilo_wb = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; imm_sl = 1'b1; reg_we = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; imm_sl = 1'b1; reg_we = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; imm_sl = 1'b1; reg_we = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  imm_sl = 1'b1; reg_we = 1'b1; end
      OP_LW:   begin alu_op = ALU_ADD; imm_sl = 1'b1; reg_we = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:   begin alu_op = ALU_ADD; imm_sl = 1'b1; mem_we = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; br = 1'b1; breq = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SUB; br = 1'b1; end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  assign wr_addr = reg_dest ? instr[15:11] : instr[20:16];

  mips16_regfile data_registers (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .raddr_a_i(instr[25:21]), .raddr_b_i(instr[20:16]),
    .rdata_a_o(rs_data), .rdata_b_o(rt_data),
    .we_i(reg_we), .waddr_i(wr_addr), .wdata_i(wb_data)
  );

  assign alu_b   = imm_sl ? imm : rt_data;
  assign alu_a_s = rs_data;
  assign alu_b_s = alu_b;

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = rs_data + alu_b;
      ALU_SUB:  alu_res = rs_data - alu_b;
      ALU_AND:  alu_res = rs_data & alu_b;
      ALU_OR:   alu_res = rs_data | alu_b;
      ALU_SLT:  alu_res = {15'd0, (alu_a_s < alu_b_s)};
      ALU_MULT: alu_res = lo_q;
      default:  alu_res = 16'd0;
    endcase
  end

  mips16_dmem data_memory (
    .clk_i(clk_i), .we_i(mem_we), .addr_i(alu_res[7:0]),
    .wdata_i(rt_data), .rdata_o(dmem_rdata)
  );

  assign wb_data = mem_to_reg ? dmem_rdata : (hilo_wb ? (hi_lo_sl ? hi_q : lo_q) : alu_res);

  // The mult instruction stays in fetch: one latch cycle, then 16 shift-add steps.
  assign alu_reset = is_mult & ~busy_q;
  assign mult_done = busy_q & (cnt_q == 4'd15);
  assign stall     = is_mult & ~mult_done;

  always_comb begin
    busy_d = busy_q; cnt_d = cnt_q; mcand_d = mcand_q; mplier_d = mplier_q;
    acc_d = acc_q; hi_d = hi_q; lo_d = lo_q;
    if (alu_reset) begin
      busy_d = 1'b1; cnt_d = 4'd0; acc_d = 32'd0;
      mcand_d = {16'd0, rs_data}; mplier_d = rt_data;
    end else if (busy_q) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 4'd1;
      if (mult_done) begin
        busy_d = 1'b0;
        {hi_d, lo_d} = acc_d;
      end
    end
  end

  assign br_taken = br & (breq ? (rs_data == rt_data) : (rs_data != rt_data));

  always_comb begin
    pc_d = pc_q + 16'd1;
    if (stall)         pc_d = pc_q;
    else if (jump_reg) pc_d = rs_data;
    else if (jump)     pc_d = imm;
    else if (br_taken) pc_d = pc_q + 16'd1 + imm;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0; hi_q <= '0; lo_q <= '0; busy_q <= 1'b0; cnt_q <= '0;
    end else begin
      pc_q <= pc_d; hi_q <= hi_d; lo_q <= lo_d; busy_q <= busy_d; cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mcand_q <= mcand_d; mplier_q <= mplier_d; acc_q <= acc_d;
  end

  assign instr_o = instr;         assign alu_op_o = alu_op;       assign wb_data_o = wb_data;
  assign rs_data_o = rs_data;     assign rt_data_o = rt_data;     assign mem_to_reg_o = mem_to_reg;
  assign mem_write_en_o = mem_we; assign reg_write_en_o = reg_we; assign alu_reset_o = alu_reset;
  assign imm_sl_o = imm_sl;       assign br_sl_o = br;            assign breq_sl_o = breq;
  assign reg_dest_o = reg_dest;   assign jump_sl_o = jump;        assign jump_reg_sl_o = jump_reg;
  assign stall_o = stall;         assign ready_o = ~busy_q & ~alu_reset;
  assign hi_lo_sl_o = hi_lo_sl;
endmodule

module mips16_sc_cpu (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] instruction,
  output logic [5:0]  op_code_out,
  output logic [5:0]  func_out,
  output logic [2:0]  alu_op_out,
  output logic [15:0] out,
  output logic [15:0] reg_data_out_a,
  output logic [15:0] reg_data_out_b,
  output logic        mem_to_reg_out,
  output logic        mem_write_en_out,
  output logic        reg_write_en_out,
  output logic        alu_reset_out,
  output logic        imm_sl_out,
  output logic        br_sl_out,
  output logic        breq_sl_out,
  output logic        reg_dest_out,
  output logic        jump_sl_out,
  output logic        jump_reg_sl_out,
  output logic        instr_stall_sl_out,
  output logic        ready_out,
  output logic        hi_lo_sl_out
);
  mips16_datapath d1 (
    .clk_i(clock), .rst_ni(reset_n), .instr_o(instruction), .alu_op_o(alu_op_out),
    .wb_data_o(out), .rs_data_o(reg_data_out_a), .rt_data_o(reg_data_out_b),
    .mem_to_reg_o(mem_to_reg_out), .mem_write_en_o(mem_write_en_out),
    .reg_write_en_o(reg_write_en_out), .alu_reset_o(alu_reset_out), .imm_sl_o(imm_sl_out),
    .br_sl_o(br_sl_out), .breq_sl_o(breq_sl_out), .reg_dest_o(reg_dest_out),
    .jump_sl_o(jump_sl_out), .jump_reg_sl_o(jump_reg_sl_out), .stall_o(instr_stall_sl_out),
    .ready_o(ready_out), .hi_lo_sl_o(hi_lo_sl_out)
  );

  assign op_code_out = instruction[31:26];
  assign func_out    = instruction[5:0];
endmodule

// File: tb/tb_mips16_sc_cpu.sv
// Bench for mips16_sc_cpu: directed programs plus random programs, checked each
// cycle against an instruction-level model of the machine.

module tb_mips16_sc_cpu;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction;
  logic [5:0]  op_code_out, func_out;
  logic [2:0]  alu_op_out;
  logic [15:0] out, reg_data_out_a, reg_data_out_b;
  logic mem_to_reg_out, mem_write_en_out, reg_write_en_out, alu_reset_out, imm_sl_out;
  logic br_sl_out, breq_sl_out, reg_dest_out, jump_sl_out, jump_reg_sl_out;
  logic instr_stall_sl_out, ready_out, hi_lo_sl_out;

  mips16_sc_cpu dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction), .op_code_out(op_code_out),
    .func_out(func_out), .alu_op_out(alu_op_out), .out(out), .reg_data_out_a(reg_data_out_a),
    .reg_data_out_b(reg_data_out_b), .mem_to_reg_out(mem_to_reg_out),
    .mem_write_en_out(mem_write_en_out), .reg_write_en_out(reg_write_en_out),
    .alu_reset_out(alu_reset_out), .imm_sl_out(imm_sl_out), .br_sl_out(br_sl_out),
    .breq_sl_out(breq_sl_out), .reg_dest_out(reg_dest_out), .jump_sl_out(jump_sl_out),
    .jump_reg_sl_out(jump_reg_sl_out), .instr_stall_sl_out(instr_stall_sl_out),
    .ready_out(ready_out), .hi_lo_sl_out(hi_lo_sl_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Architectural model: program, registers, data memory, pc, hi/lo, mult progress.
  logic [31:0] im [256];
  logic [15:0] R  [32];
  logic [15:0] M  [256];
  logic [15:0] pc, hi, lo;
  logic [31:0] mprod;
  int          mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rt_i(input logic [4:0] rs, rt, rd, input logic [5:0] f);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic push_imem();
    for (int i = 0; i < 256; i++) dut.d1.instruction_registers.register[i] <= im[i];
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    push_imem();
    pc = 16'd0; hi = 16'd0; lo = 16'd0; mcnt = 0;
    for (int i = 0; i < 32; i++) R[i] = 16'd0;
    @(negedge clock);
    #2 reset_n = 1'b1;
  endtask

  // Compare the current cycle against the model, advance the model, wait one clock.
  task automatic check_cycle();
    logic [31:0] ins;
    logic [5:0]  op, f;
    logic [4:0]  rs, rt, rd, dst;
    logic [15:0] imm, a, b, res, npc, nhi, nlo, sum;
    logic        we, mwe, stl, rdy, arst;
    ins = im[pc[7:0]];
    op = ins[31:26]; f = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    imm = ins[15:0]; a = R[rs]; b = R[rt];
    we = 1'b0; mwe = 1'b0; stl = 1'b0; rdy = 1'b1; arst = 1'b0; res = 16'd0; dst = 5'd0;
    npc = pc + 16'd1; nhi = hi; nlo = lo; sum = a + imm;
    case (op)
      6'h00: case (f)
        6'h20: begin we = 1'b1; dst = rd; res = a + b; end
        6'h22: begin we = 1'b1; dst = rd; res = a - b; end
        6'h24: begin we = 1'b1; dst = rd; res = a & b; end
        6'h25: begin we = 1'b1; dst = rd; res = a | b; end
        6'h2A: begin we = 1'b1; dst = rd; res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; end
        6'h08: npc = a;
        6'h10: begin we = 1'b1; dst = rd; res = hi; end
        6'h12: begin we = 1'b1; dst = rd; res = lo; end
        6'h18: begin
          rdy = 1'b0;
          if (mcnt == 0) begin arst = 1'b1; mprod = {16'd0, a} * {16'd0, b}; end
          if (mcnt < 16) begin stl = 1'b1; npc = pc; mcnt++; end
          else begin mcnt = 0; nhi = mprod[31:16]; nlo = mprod[15:0]; end
        end
        default: ;
      endcase
      6'h08: begin we = 1'b1; dst = rt; res = a + imm; end
      6'h0A: begin we = 1'b1; dst = rt; res = ($signed(a) < $signed(imm)) ? 16'd1 : 16'd0; end
      6'h0C: begin we = 1'b1; dst = rt; res = a & imm; end
      6'h0D: begin we = 1'b1; dst = rt; res = a | imm; end
      6'h23: begin we = 1'b1; dst = rt; res = M[sum[7:0]]; end
      6'h2B: mwe = 1'b1;
      6'h04: if (a == b) npc = pc + 16'd1 + imm;
      6'h05: if (a != b) npc = pc + 16'd1 + imm;
      6'h02: npc = imm;
      default: ;
    endcase
    chk("pc", dut.d1.pc_q, pc);
    chk("instruction", instruction, ins);
    chk("reg_write_en", reg_write_en_out, we);
    chk("mem_write_en", mem_write_en_out, mwe);
    chk("stall", instr_stall_sl_out, stl);
    chk("ready", ready_out, rdy);
    chk("alu_reset", alu_reset_out, arst);
    if (we) chk("writeback", out, res);
    if (mwe) chk("store_data", reg_data_out_b, b);
    if (we && dst != 5'd0) R[dst] = res;
    if (mwe) M[sum[7:0]] = b;
    pc = npc; hi = nhi; lo = nlo;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) check_cycle();
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 32; i++) chk(tag, dut.d1.data_registers.register[i], R[i]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm, off;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom); off = 16'($urandom_range(0, 12)) - 16'd4;
    case ($urandom_range(0, 19))
      0:  return rt_i(rs, rt, rd, 6'h20);
      1:  return rt_i(rs, rt, rd, 6'h22);
      2:  return rt_i(rs, rt, rd, 6'h24);
      3:  return rt_i(rs, rt, rd, 6'h25);
      4:  return rt_i(rs, rt, rd, 6'h2A);
      5:  return rt_i(rs, rt, 5'd0, 6'h18);
      6:  return rt_i(5'd0, 5'd0, rd, 6'h10);
      7:  return rt_i(5'd0, 5'd0, rd, 6'h12);
      8:  return it_i(6'h08, rs, rt, imm);
      9:  return it_i(6'h0A, rs, rt, imm);
      10: return it_i(6'h0C, rs, rt, imm);
      11: return it_i(6'h0D, rs, rt, imm);
      12: return it_i(6'h23, 5'd0, rt, 16'($urandom_range(0, 15)));
      13: return it_i(6'h2B, 5'd0, rt, 16'($urandom_range(0, 15)));
      14: return it_i(6'h04, rs, rt, off);
      15: return it_i(6'h05, rs, rt, off);
      16: return it_i(6'h02, 5'd0, 5'd0, 16'($urandom_range(16, 255)));
      17: return rt_i(rs, 5'd0, 5'd0, 6'h08);
      18: return it_i(6'h3F, rs, rt, imm);
      default: return rt_i(rs, rt, rd, 6'h3E);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstall;
    for (int i = 0; i < 256; i++) M[i] = 16'd0;

    // addi $1,$0,42 from reset
    for (int i = 0; i < 256; i++) im[i] = 32'd0;
    im[0] = it_i(6'h08, 5'd0, 5'd1, 16'h002A);
    do_reset();
    chk("reset_ready", ready_out, 1'b1);
    chk("reset_stall", instr_stall_sl_out, 1'b0);
    chk("reset_hi", dut.d1.hi_q, 16'd0);
    chk("addi_imm_sl", imm_sl_out, 1'b1);
    chk("addi_out", out, 16'd42);
    run(3);
    chk("addi_reg1", dut.d1.data_registers.register[1], 16'd42);

    // ALU, memory, branch and jump program
    for (int i = 0; i < 256; i++) im[i] = 32'd0;
    im[0]  = it_i(6'h08, 5'd0, 5'd1, 16'd5);
    im[1]  = it_i(6'h08, 5'd0, 5'd2, 16'd7);
    im[2]  = rt_i(5'd1, 5'd2, 5'd3, 6'h20);
    im[3]  = rt_i(5'd1, 5'd2, 5'd4, 6'h22);
    im[4]  = rt_i(5'd4, 5'd1, 5'd5, 6'h2A);
    im[5]  = it_i(6'h08, 5'd0, 5'd1, 16'd42);
    im[6]  = it_i(6'h2B, 5'd0, 5'd1, 16'd3);
    im[7]  = it_i(6'h23, 5'd0, 5'd6, 16'd3);
    im[8]  = it_i(6'h04, 5'd1, 5'd1, 16'd2);
    im[11] = it_i(6'h05, 5'd1, 5'd1, 16'd2);
    im[12] = it_i(6'h02, 5'd0, 5'd0, 16'h0020);
    im[32] = it_i(6'h08, 5'd0, 5'd9, 16'd40);
    im[33] = rt_i(5'd9, 5'd0, 5'd0, 6'h08);
    do_reset();
    run(7);
    chk("lw_mem_to_reg", mem_to_reg_out, 1'b1);
    run(2);
    chk("beq_taken_pc", dut.d1.pc_q, 16'd11);
    run(1);
    chk("bne_not_taken_pc", dut.d1.pc_q, 16'd12);
    run(1);
    chk("j_pc", dut.d1.pc_q, 16'd32);
    run(2);
    chk("jr_pc", dut.d1.pc_q, 16'd40);
    chk("add_reg3", dut.d1.data_registers.register[3], 16'd12);
    chk("sub_reg4", dut.d1.data_registers.register[4], 16'hFFFE);
    chk("slt_reg5", dut.d1.data_registers.register[5], 16'd1);
    chk("lw_reg6", dut.d1.data_registers.register[6], 16'd42);
    chk("sw_dmem3", dut.d1.data_memory.mem[3], 16'd42);
    check_state("regs_directed");

    // 300*300 through mult, then mflo/mfhi
    for (int i = 0; i < 256; i++) im[i] = 32'd0;
    im[0] = it_i(6'h08, 5'd0, 5'd1, 16'd300);
    im[1] = it_i(6'h08, 5'd0, 5'd2, 16'd300);
    im[2] = rt_i(5'd1, 5'd2, 5'd0, 6'h18);
    im[3] = rt_i(5'd0, 5'd0, 5'd7, 6'h12);
    im[4] = rt_i(5'd0, 5'd0, 5'd8, 6'h10);
    do_reset();
    run(2);
    nstall = 0;
    while (instr_stall_sl_out === 1'b1 && nstall < 40) begin
      nstall++;
      check_cycle();
    end
    chk("mult_stall_cycles", nstall, 16);
    run(3);
    chk("mflo_reg7", dut.d1.data_registers.register[7], 16'h5F90);
    chk("mfhi_reg8", dut.d1.data_registers.register[8], 16'h0001);

    // reset asserted in the middle of the multiply
    do_reset();
    run(7);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_pc", dut.d1.pc_q, 16'd0);
    chk("abort_ready", ready_out, 1'b1);
    chk("abort_stall", instr_stall_sl_out, 1'b0);
    @(negedge clock);
    @(negedge clock);
    chk("abort_hi", dut.d1.hi_q, 16'd0);
    chk("abort_lo", dut.d1.lo_q, 16'd0);
    do_reset();
    run(25);
    chk("rerun_reg7", dut.d1.data_registers.register[7], 16'h5F90);

    // random programs: zeroing prologue over dmem[0..15], then random code
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) im[i] = it_i(6'h2B, 5'd0, 5'd0, 16'(i));
      for (int i = 16; i < 256; i++) im[i] = rand_instr();
      do_reset();
      run(400);
      check_state("regs_random");
      for (int i = 0; i < 16; i++) chk("dmem_random", dut.d1.data_memory.mem[i], M[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
